// File: rtl/if_id_pipeline_reg.sv
// IF/ID pipeline register: latches the fetched instruction, its PC and the sequential next PC.
// Supports stall, bubble insertion and a valid flag, and pre-splits the instruction into MIPS fields.
module if_id_pipeline_reg #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_PC  = 32'h0000_3000,
    parameter logic [WIDTH-1:0]   NOP_INSTR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] next_PC,
    input  logic             EN,
    input  logic             flush,
    output logic [WIDTH-1:0] next_instr,
    output logic [WIDTH-1:0] D_PC,
    output logic [WIDTH-1:0] D_next_PC,
    output logic             D_valid,
    output logic [5:0]       D_opcode,
    output logic [4:0]       D_rs,
    output logic [4:0]       D_rt,
    output logic [4:0]       D_rd,
    output logic [4:0]       D_shamt,
    output logic [5:0]       D_funct,
    output logic [15:0]      D_imm16,
    output logic [25:0]      D_imm26
);

    localparam logic [WIDTH-1:0] RESET_NEXT_PC = RESET_PC + WIDTH'(4);

    // Update priority at each rising edge: flush loads a bubble regardless of EN;
    // otherwise EN=1 captures the IF-stage values and EN=0 holds everything (stall).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_instr <= NOP_INSTR;
            D_PC       <= RESET_PC;
            D_next_PC  <= RESET_NEXT_PC;
            D_valid    <= 1'b0;
        end else if (flush) begin
            next_instr <= NOP_INSTR;
            D_PC       <= RESET_PC;
            D_next_PC  <= RESET_NEXT_PC;
            D_valid    <= 1'b0;
        end else if (EN) begin
            next_instr <= instr;
            D_PC       <= PC;
            D_next_PC  <= next_PC;
            D_valid    <= 1'b1;
        end
    end

    // Decoder fields are plain slices of the registered word, so they track it with no extra delay.
    assign D_opcode = next_instr[31:26];
    assign D_rs     = next_instr[25:21];
    assign D_rt     = next_instr[20:16];
    assign D_rd     = next_instr[15:11];
    assign D_shamt  = next_instr[10:6];
    assign D_funct  = next_instr[5:0];
    assign D_imm16  = next_instr[15:0];
    assign D_imm26  = next_instr[25:0];

endmodule

// File: tb/tb_if_id_pipeline_reg.sv
// Bench for if_id_pipeline_reg: directed vector table plus hand-written sequences for
// asynchronous reset, reset during stall and a back-to-back instruction stream.
module tb_if_id_pipeline_reg;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] PC;
    logic [31:0] next_PC;
    logic        EN;
    logic        flush;
    logic [31:0] next_instr;
    logic [31:0] D_PC;
    logic [31:0] D_next_PC;
    logic        D_valid;
    logic [5:0]  D_opcode;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [4:0]  D_rd;
    logic [4:0]  D_shamt;
    logic [5:0]  D_funct;
    logic [15:0] D_imm16;
    logic [25:0] D_imm26;

    int checks = 0;
    int errors = 0;

    logic [95:0] exp_q[$];

    if_id_pipeline_reg dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .PC         (PC),
        .next_PC    (next_PC),
        .EN         (EN),
        .flush      (flush),
        .next_instr (next_instr),
        .D_PC       (D_PC),
        .D_next_PC  (D_next_PC),
        .D_valid    (D_valid),
        .D_opcode   (D_opcode),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_rd       (D_rd),
        .D_shamt    (D_shamt),
        .D_funct    (D_funct),
        .D_imm16    (D_imm16),
        .D_imm26    (D_imm26)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        flush;
        logic        en;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_npc;
        logic        e_valid;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                             input logic [31:0] en_pc, input logic ev);
        chk({tag, ".instr"},  next_instr, ei);
        chk({tag, ".pc"},     D_PC, ep);
        chk({tag, ".npc"},    D_next_PC, en_pc);
        chk({tag, ".valid"},  {31'd0, D_valid}, {31'd0, ev});
        chk({tag, ".opcode"}, {26'd0, D_opcode}, {26'd0, ei[31:26]});
        chk({tag, ".rs"},     {27'd0, D_rs}, {27'd0, ei[25:21]});
        chk({tag, ".rt"},     {27'd0, D_rt}, {27'd0, ei[20:16]});
        chk({tag, ".rd"},     {27'd0, D_rd}, {27'd0, ei[15:11]});
        chk({tag, ".shamt"},  {27'd0, D_shamt}, {27'd0, ei[10:6]});
        chk({tag, ".funct"},  {26'd0, D_funct}, {26'd0, ei[5:0]});
        chk({tag, ".imm16"},  {16'd0, D_imm16}, {16'd0, ei[15:0]});
        chk({tag, ".imm26"},  {6'd0, D_imm26}, {6'd0, ei[25:0]});
    endtask

    // Driver: set inputs on the falling edge, then let one rising edge pass and settle.
    task automatic drive(input logic fl, input logic en, input logic [31:0] i,
                         input logic [31:0] p, input logic [31:0] np);
        @(negedge clk);
        flush   = fl;
        EN      = en;
        instr   = i;
        PC      = p;
        next_PC = np;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [95:0] e;
        logic [31:0] ri;

        //            flush en   instr         pc            npc           e_instr       e_pc          e_npc         e_valid
        vecs[0] = '{1'b0, 1'b1, 32'h8C220004, 32'h00003000, 32'h00003004, 32'h8C220004, 32'h00003000, 32'h00003004, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 32'h00851020, 32'h00003004, 32'h00003008, 32'h8C220004, 32'h00003000, 32'h00003004, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 32'h00851020, 32'h00003004, 32'h00003008, 32'h8C220004, 32'h00003000, 32'h00003004, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 32'h00851020, 32'h00003004, 32'h00003008, 32'h8C220004, 32'h00003000, 32'h00003004, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 32'h00851020, 32'h00003004, 32'h00003008, 32'h00851020, 32'h00003004, 32'h00003008, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 32'h1000FFFF, 32'h00003008, 32'h0000300C, 32'h00000000, 32'h00003000, 32'h00003004, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'h1000FFFF, 32'h00003008, 32'h0000300C, 32'h1000FFFF, 32'h00003008, 32'h0000300C, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 32'h2402ABCD, 32'h0000300C, 32'h00003010, 32'h00000000, 32'h00003000, 32'h00003004, 1'b0};

        // Reset with the clock running; inputs carry live-looking data that must be ignored.
        reset = 1'b1; EN = 1'b1; flush = 1'b0;
        instr = 32'hDEADBEEF; PC = 32'h00001234; next_PC = 32'h00001238;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 32'h0, 32'h3000, 32'h3004, 1'b0);
        @(negedge clk);
        reset = 1'b0; EN = 1'b0;
        @(posedge clk); #1;
        check_all("post_reset_hold", 32'h0, 32'h3000, 32'h3004, 1'b0);

        // Directed table: capture, stall, release, flush with and without EN.
        for (int k = 0; k < 8; k++) begin
            drive(vecs[k].flush, vecs[k].en, vecs[k].instr, vecs[k].pc, vecs[k].npc);
            check_all($sformatf("vec%0d", k), vecs[k].e_instr, vecs[k].e_pc, vecs[k].e_npc, vecs[k].e_valid);
        end

        // Reset during a stall clears immediately, between clock edges.
        drive(1'b0, 1'b1, 32'h8C430008, 32'h00003010, 32'h00003014);
        check_all("pre_stall", 32'h8C430008, 32'h3010, 32'h3014, 1'b1);
        drive(1'b0, 1'b0, 32'h11111111, 32'h00003014, 32'h00003018);
        check_all("stall", 32'h8C430008, 32'h3010, 32'h3014, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 32'h0, 32'h3000, 32'h3004, 1'b0);
        @(posedge clk); #1;
        // Release with EN=1: the very next edge captures the current inputs.
        drive(1'b0, 1'b1, 32'h03E00008, 32'h00003020, 32'h00003024);
        reset = 1'b0;
        @(posedge clk); #1;
        check_all("reset_release", 32'h03E00008, 32'h3020, 32'h3024, 1'b1);

        // Back-to-back stream: each edge must show exactly the previous cycle's inputs.
        for (int k = 0; k < 8; k++) begin
            ri = $urandom;
            e  = {ri, 32'h00004000 + 32'(k * 4), 32'h00004004 + 32'(k * 4)};
            exp_q.push_back(e);
            drive(1'b0, 1'b1, e[95:64], e[63:32], e[31:0]);
            e = exp_q.pop_front();
            check_all($sformatf("stream%0d", k), e[95:64], e[63:32], e[31:0], 1'b1);
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_pipeline_reg.md
Name: if_id_pipeline_reg

Overview:
IF/ID pipeline register of the 5-stage MIPS-style pipelined CPU. It latches the fetched instruction, its PC and the sequential next PC from the IF stage, and presents them to the ID stage. It supports stall (hold), flush (bubble insertion) and a valid flag. It also pre-splits the latched instruction into its standard MIPS fields for the decoder.

Parameters:
WIDTH, 32, data/address width of instr, PC and next_PC.
RESET_PC, 32'h0000_3000, value loaded into the ID-stage PC on reset or flush.
NOP_INSTR, 32'h0000_0000, instruction word inserted on reset or flush (sll $0,$0,0).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high; clears all state.
instr  in  32  instruction fetched in IF.
PC  in  32  address of instr.
next_PC  in  32  sequential successor address from IF (PC+4), carried for link/branch use.
EN  in  1  load enable; 1 = capture, 0 = stall (hold).
flush  in  1  synchronous bubble request, active-high.
next_instr  out  32  registered instruction for ID.
D_PC  out  32  registered PC.
D_next_PC  out  32  registered next_PC.
D_valid  out  1  1 = the ID slot holds a real fetched instruction.
D_opcode  out  6  next_instr[31:26].
D_rs  out  5  next_instr[25:21].
D_rt  out  5  next_instr[20:16].
D_rd  out  5  next_instr[15:11].
D_shamt  out  5  next_instr[10:6].
D_funct  out  6  next_instr[5:0].
D_imm16  out  16  next_instr[15:0].
D_imm26  out  26  next_instr[25:0].

Behaviour:
- Reset is asynchronous, active-high, with one clock. While reset=1: next_instr=NOP_INSTR, D_PC=RESET_PC, D_next_PC=RESET_PC+4, D_valid=0. These values persist after reset deasserts until the first capturing edge.
- Register updates happen on the rising clk edge, using the following priority: reset > flush > EN.
- flush=1 at an edge: load the bubble (NOP_INSTR, RESET_PC, RESET_PC+4, valid=0). EN is ignored.
- flush=0, EN=1: next_instr<=instr, D_PC<=PC, D_next_PC<=next_PC, D_valid<=1. Latency is 1 cycle.
- flush=0, EN=0: all registers hold their values (stall). Stalls may last any number of cycles.
- Field outputs are purely combinational slices of the registered next_instr. They add no latency and follow reset, flush and stall automatically.
- The block does no arithmetic. next_PC is passed through unchanged and is not checked against PC+4.
- If reset is asserted mid-stall or mid-flush, it takes effect immediately.
- If reset is released with EN=1, the first capture occurs at the next rising edge.
- X or undriven inputs are captured only when EN=1 and flush=0.

Test Plan:
- Reset: reset=1, clk toggling -> next_instr=0, D_PC=0x3000, D_next_PC=0x3004, D_valid=0. Asynchronous check: assert reset between edges -> outputs clear without waiting for a clock.
- Capture: reset=0, EN=1, instr=0x8C220004, PC=0x3000, next_PC=0x3004, one edge -> outputs equal the inputs, D_valid=1, D_opcode=0x23, D_rs=1, D_rt=2, D_imm16=0x0004.
- Stall: after capture, set EN=0, instr=0x00851020, PC=0x3004 for 3 edges -> outputs still 0x8C220004/0x3000. Set EN=1, one edge -> next_instr=0x00851020, D_rd=2, D_funct=0x20.
- Flush: flush=1 with EN=1 and instr=0x1000FFFF -> after the edge next_instr=0, D_valid=0, D_PC=0x3000. Repeat with flush=1, EN=0 -> bubble still inserted.
- Pipelined stream: EN=1 and PC stepping by 4 for 8 cycles -> each output equals the previous cycle's input, with no skips or duplicates.
- Reset during stall: EN=0 holding valid data, pulse reset mid-cycle -> immediate clear. After release with EN=1, next edge captures the current inputs.
